regfile_onehot_32: RTL and testbench

// - 32 x 32-bit CPU register file. Write port is driven by the one-hot

---
 rtl/regfile_onehot_32_if.sv | 22 ++
 rtl/regfile_onehot_32.sv | 46 ++++
 tb/tb_regfile_onehot_32.sv | 128 ++++++++++++
 3 files changed

// File: rtl/regfile_onehot_32_if.sv
// regfile_onehot_32_if: write/read bus of the one-hot register file
interface regfile_onehot_32_if #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
);
  logic [DEPTH-1:0]  we_onehot;
  logic [WIDTH-1:0]  data_writeReg;
  logic [ADDR_W-1:0] ctrl_readRegA;
  logic [ADDR_W-1:0] ctrl_readRegB;
  logic [WIDTH-1:0]  data_readRegA;
  logic [WIDTH-1:0]  data_readRegB;
  logic              onehot_err;
  modport master (
    output we_onehot, data_writeReg, ctrl_readRegA, ctrl_readRegB,
    input  data_readRegA, data_readRegB, onehot_err
  );
  modport slave (
    input  we_onehot, data_writeReg, ctrl_readRegA, ctrl_readRegB,
    output data_readRegA, data_readRegB, onehot_err
  );
endinterface

// File: rtl/regfile_onehot_32.sv
// regfile_onehot_32: 32x32 register file, one-hot write port, write-first bypassed reads, sticky multi-hot error
module regfile_onehot_32 #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input logic              clock,
  input logic              ctrl_reset_n,
  regfile_onehot_32_if.slave bus
);
  logic [WIDTH-1:0]  regs [DEPTH];
  logic [DEPTH-1:0]  wr_sel;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic              no_we;
  logic              multi_we;
  logic              single_we;
  logic              err;
  // x & (x-1) clears the lowest set bit, so any remainder means two or more enables
  assign no_we     = ~|bus.we_onehot;
  assign multi_we  = |(bus.we_onehot & (bus.we_onehot - DEPTH'(1)));
  assign single_we = ~no_we & ~multi_we;
  // Only a clean single enable on a non-zero register writes; it also selects the bypass
  assign wr_sel    = single_we ? {bus.we_onehot[DEPTH-1:1], 1'b0} : '0;
  assign addr_a    = bus.ctrl_readRegA;
  assign addr_b    = bus.ctrl_readRegB;
  // Read ports: zero in reset or at address 0, else write-first bypass, else stored value
  assign bus.data_readRegA = (!ctrl_reset_n || addr_a == '0) ? '0 :
                             wr_sel[addr_a] ? bus.data_writeReg : regs[addr_a];
  assign bus.data_readRegB = (!ctrl_reset_n || addr_b == '0) ? '0 :
                             wr_sel[addr_b] ? bus.data_writeReg : regs[addr_b];
  assign bus.onehot_err    = err;
  // Register array; entry 0 is only ever cleared, so it stays zero
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) if (wr_sel[i]) regs[i] <= bus.data_writeReg;
    end
  end
  // Sticky error: set by any multi-hot enable vector, cleared only by reset
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) err <= 1'b0;
    else if (multi_we) err <= 1'b1;
  end
endmodule

// File: tb/tb_regfile_onehot_32.sv
// tb_regfile_onehot_32: scoreboard bench for the one-hot register file against a behavioural model
module tb_regfile_onehot_32;
  logic clock = 1'b0;
  logic ctrl_reset_n = 1'b0;
  regfile_onehot_32_if bus ();
  regfile_onehot_32 dut (.clock(clock), .ctrl_reset_n(ctrl_reset_n), .bus(bus));
  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [31:0] a;
    logic [31:0] b;
    logic        err;
  } exp_t;

  exp_t        sb [$];
  exp_t        cur;
  logic [31:0] model [32];
  logic        model_err;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] exp_rd(input logic rn, input logic [31:0] we,
                                         input logic [31:0] d, input logic [4:0] addr);
    if (!rn || addr == 0) return 32'h0;
    if ($countones(we) == 1 && we[addr]) return d;
    return model[addr];
  endfunction

  task automatic step(input string tag, input logic rn, input logic [31:0] we,
                      input logic [31:0] d, input logic [4:0] ra, input logic [4:0] rb);
    exp_t e;
    ctrl_reset_n      = rn;
    bus.we_onehot     = we;
    bus.data_writeReg = d;
    bus.ctrl_readRegA = ra;
    bus.ctrl_readRegB = rb;
    if (!rn) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      model_err = 1'b0;
    end
    e.tag = tag;
    e.a   = exp_rd(rn, we, d, ra);
    e.b   = exp_rd(rn, we, d, rb);
    e.err = model_err;
    sb.push_back(e);
    @(posedge clock);
    if (rn) begin
      if ($countones(we) >= 2) model_err = 1'b1;
      else if ($countones(we) == 1)
        for (int k = 1; k < 32; k++) if (we[k]) model[k] = d;
    end
    #1;
  endtask

  task automatic chk(input string tag, input string what, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s %s: got %h want %h", tag, what, got, want);
    end
  endtask

  always @(negedge clock) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      chk(cur.tag, "readA", bus.data_readRegA, cur.a);
      chk(cur.tag, "readB", bus.data_readRegB, cur.b);
      chk(cur.tag, "err", {31'h0, bus.onehot_err}, {31'h0, cur.err});
    end
  end

  initial begin
    logic [31:0] we;
    logic [4:0]  ra;
    logic [4:0]  rb;
    int          r;
    int          i0;
    int          i1;
    bus.we_onehot = '0;
    bus.data_writeReg = '0;
    bus.ctrl_readRegA = '0;
    bus.ctrl_readRegB = '0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    model_err = 1'b0;
    @(posedge clock);
    #1;
    step("rst_hold", 1'b0, 32'h0000_0020, 32'h5555_5555, 5'd5, 5'd31);
    for (int i = 0; i < 32; i++) step("rst_sweep", 1'b1, 32'h0, 32'h0, 5'(i), 5'(31 - i));
    step("bypass_r5", 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 5'd5, 5'd5);
    step("held_r5", 1'b1, 32'h0, 32'h0, 5'd5, 5'd0);
    step("r0_write", 1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0, 5'd5);
    step("r0_after", 1'b1, 32'h0, 32'h0, 5'd0, 5'd0);
    step("wr_r7", 1'b1, 32'h0000_0080, 32'h1234_5678, 5'd7, 5'd3);
    step("multi_hot", 1'b1, 32'h0000_0088, 32'hAAAA_AAAA, 5'd3, 5'd7);
    step("multi_after", 1'b1, 32'h0, 32'h0, 5'd3, 5'd7);
    step("valid_after_err", 1'b1, 32'h0000_0004, 32'h0BAD_F00D, 5'd2, 5'd7);
    step("err_sticky", 1'b1, 32'h0, 32'h0, 5'd2, 5'd0);
    for (int k = 1; k < 32; k++) step("fill", 1'b1, 32'h1 << k, 32'(k + 1), 5'(k), 5'd0);
    for (int k = 0; k < 32; k++) step("fill_sweep", 1'b1, 32'h0, 32'h0, 5'(k), 5'(31 - k));
    step("rst_mid", 1'b0, 32'h0000_0200, 32'h9999_9999, 5'd9, 5'd10);
    step("rst_mid_edge", 1'b0, 32'h0000_0200, 32'h9999_9999, 5'd9, 5'd9);
    step("rst_release", 1'b1, 32'h0, 32'h0, 5'd9, 5'd10);
    step("post_rst_wr", 1'b1, 32'h0000_0200, 32'h7777_0009, 5'd9, 5'd9);
    step("post_rst_rd", 1'b1, 32'h0, 32'h0, 5'd9, 5'd10);
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      i0 = $urandom_range(0, 31);
      i1 = (i0 + 1 + $urandom_range(0, 30)) % 32;
      we = (r == 0) ? 32'h0 : (r == 1) ? 32'h1 :
           (r == 2) ? ((32'h1 << i0) | (32'h1 << i1)) : (32'h1 << $urandom_range(1, 31));
      ra = 5'($urandom_range(0, 31));
      rb = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) for (int k = 0; k < 32; k++) if (we[k]) ra = 5'(k);
      if ($urandom_range(0, 3) == 0) rb = ra;
      step("random", 1'b1, we, $urandom, ra, rb);
    end
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clock);
    #1;
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
